mc_ctrl_unit: RTL and testbench
===============================

// Module: mc_ctrl_unit
// PURPOSE
//  Multicycle control FSM that drives the shared datapath ALU, the other end of the ALU's aluc/z interface.
//  - Decodes the MIPS opcode (op) and function field (func) from the instruction register.
//  - Sequences each instruction through IF/ID/EXE/MEM/WB.
//  - Emits aluc in the ALU encoding, plus all datapath write-enables and mux selects.
//  - Consumes the ALU zero flag z to resolve beq/bne.
// PARAMETERS
//  WAIT_MEM  1  1: stall in IF/MEM until mrdy=1; 0: ignore mrdy, memory is always ready
// PORTS
//  clk       in   1  rising-edge clock
//  clrn      in   1  asynchronous active-low reset
//  op        in   6  IR[31:26]
//  func      in   6  IR[5:0]
//  z         in   1  ALU zero flag, same cycle as aluc
//  mrdy      in   1  memory ready (IF fetch / MEM access complete)
//  aluc      out  4  ALU op: ADD 0000, SUB 0100, AND 0001, OR 0101, XOR 0010, LUI 0110, SLL 0011, SRL 0111, SRA 1111
//  wpc       out  1  PC write enable
//  wir       out  1  IR write enable
//  wmem      out  1  data memory write enable
//  wreg      out  1  register file write enable
//  iord      out  1  memory address select: 0 = PC, 1 = ALU-out
//  alusrca   out  2  ALU A select: 00 = PC, 01 = rs, 10 = sa
//  alusrcb   out  2  ALU B select: 00 = rt, 01 = const 4, 10 = imm, 11 = imm<<2
//  sext      out  1  1 = sign-extend imm; 0 = zero-extend
//  pcsource  out  2  PC source: 00 = ALU, 01 = ALU-out (branch), 10 = jump target, 11 = rs
//  regrt     out  1  destination register: 1 = rt, 0 = rd
//  m2reg     out  1  write-back data: 1 = MDR, 0 = ALU-out
//  jal       out  1  force dest $31 and data PC+4
//  illegal   out  1  1-cycle pulse in ID for an undecoded op/func
//  state     out  3  current state, for debug
// BEHAVIOUR
//  - State register is the only flop; all other outputs are Moore/Mealy decodes of state, op, func and z.
//  - clrn=0: state <= SIF. While clrn=0, wpc/wir/wmem/wreg/illegal are forced to 0.
//  - Reset released mid-instruction always restarts at SIF; partial instructions are discarded.
//  - SIF: iord=0, wir=1, alusrca=00, alusrcb=01, aluc=ADD, pcsource=00, wpc=1.
//    If mrdy=0 and WAIT_MEM=1: hold SIF with wir=wpc=0. Otherwise -> SID.
//  - SID: alusrca=00, alusrcb=11, sext=1, aluc=ADD (branch target into ALU-out).
//    - j: wpc=1, pcsource=10. -> SIF.
//    - jr: wpc=1, pcsource=11. -> SIF.
//    - jal: wpc=1, pcsource=10, wreg=1, jal=1. -> SIF.
//    - Illegal op/func: illegal=1. -> SIF (executes as nop).
//    - All others -> SEXE.
//  - SEXE:
//    - R-type: alusrca=01 (10 for sll/srl/sra), alusrcb=00, aluc from func. -> SWB.
//    - addi/andi/ori/xori/lui: alusrcb=10; sext=1 only for addi. -> SWB.
//    - lw/sw: alusrca=01, alusrcb=10, sext=1, aluc=ADD. -> SMEM.
//    - beq/bne: alusrca=01, alusrcb=00, aluc=SUB, pcsource=01, wpc=(beq&z)|(bne&~z). -> SIF.
//  - SMEM: iord=1.
//    - sw: wmem=1. -> SIF.
//    - lw -> SWB.
//    - If mrdy=0 and WAIT_MEM=1: hold SMEM with wmem=0.
//  - SWB: wreg=1. regrt=1 for I-type, 0 for R-type. m2reg=1 for lw. -> SIF.
//  - Cycle counts with mrdy held 1:
//    - j/jr/jal: 2
//    - beq/bne: 3
//    - R-type/ALU-imm/sw: 4
//    - lw: 5
//  - Outputs not listed for a state are 0.
//  - The write enables wpc/wir/wmem/wreg are never asserted together with an unknown state. Unreachable state encodings -> SIF.
// STRUCTURE
//  - Shared include mc_defs.vh holds:
//    - opcode and func constants
//    - ALUC_* codes, matching the ALU decode
//    - state encodings SIF=0 .. SWB=4
//  - Sub-module mc_inst_dec: combinational op/func -> one-hot instruction flags (i_add .. i_jal, i_illegal).
//  - mc_ctrl_unit holds the FSM and the output decode.
// TESTING
//  1. Reset then addi (op=001000), mrdy=1:
//     states SIF,SID,SEXE,SWB,SIF; aluc=0000, alusrcb=10, sext=1, regrt=1, wreg=1 in cycle 4 only.
//  2. lw (op=100011):
//     5 cycles; iord=1 in SMEM; m2reg=1 and wreg=1 in SWB.
//     Repeat with mrdy=0 for 3 cycles in SMEM: SMEM is held for 3 extra cycles and wreg stays 0.
//  3. beq with z=1: wpc=1 and pcsource=01 in SEXE.
//     beq with z=0: wpc=0.
//     bne is the mirror of both. Each takes 3 cycles.
//  4. sll (op=0, func=000000): aluc=0011, alusrca=10.
//     sra (func=000011): aluc=1111.
//     xor (func=100110): aluc=0010.
//  5. jal (op=000011): in SID, wpc=1, pcsource=10, wreg=1, jal=1; back to SIF after 2 cycles.
//     op=111111: illegal pulses 1 cycle, no write enables, returns to SIF.
//  6. clrn driven low asynchronously in SMEM of sw:
//     wmem drops to 0 immediately; state=SIF; after release, a fetch begins.

Source files
------------

// File: rtl/mc_ctrl_unit_pkg.sv
// Shared constants for the multicycle MIPS control unit: opcodes, func codes,
// ALU op encodings, FSM state encodings and the decoded-instruction struct.
package mc_ctrl_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;

    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    localparam logic [2:0] SIF  = 3'd0;
    localparam logic [2:0] SID  = 3'd1;
    localparam logic [2:0] SEXE = 3'd2;
    localparam logic [2:0] SMEM = 3'd3;
    localparam logic [2:0] SWB  = 3'd4;

    typedef struct packed {
        logic i_add, i_sub, i_and, i_or, i_xor;
        logic i_sll, i_srl, i_sra, i_jr;
        logic i_addi, i_andi, i_ori, i_xori, i_lui;
        logic i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
        logic i_illegal;
    } inst_t;

    // ALU op for the EXE phase of R-type and ALU-immediate instructions
    function automatic logic [3:0] alu_of(inst_t d);
        if (d.i_sub)                   return ALUC_SUB;
        else if (d.i_and  || d.i_andi) return ALUC_AND;
        else if (d.i_or   || d.i_ori)  return ALUC_OR;
        else if (d.i_xor  || d.i_xori) return ALUC_XOR;
        else if (d.i_lui)              return ALUC_LUI;
        else if (d.i_sll)              return ALUC_SLL;
        else if (d.i_srl)              return ALUC_SRL;
        else if (d.i_sra)              return ALUC_SRA;
        else                           return ALUC_ADD;
    endfunction

endpackage

// File: rtl/mc_inst_dec.sv
// Combinational op/func decode into one-hot instruction flags; anything not
// recognised raises i_illegal.
module mc_inst_dec
    import mc_ctrl_unit_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output inst_t      inst
);

    logic rtype;
    assign rtype = (op == OP_RTYPE);

    always_comb begin
        inst        = '0;
        inst.i_add  = rtype && (func == FN_ADD);
        inst.i_sub  = rtype && (func == FN_SUB);
        inst.i_and  = rtype && (func == FN_AND);
        inst.i_or   = rtype && (func == FN_OR);
        inst.i_xor  = rtype && (func == FN_XOR);
        inst.i_sll  = rtype && (func == FN_SLL);
        inst.i_srl  = rtype && (func == FN_SRL);
        inst.i_sra  = rtype && (func == FN_SRA);
        inst.i_jr   = rtype && (func == FN_JR);
        inst.i_addi = (op == OP_ADDI);
        inst.i_andi = (op == OP_ANDI);
        inst.i_ori  = (op == OP_ORI);
        inst.i_xori = (op == OP_XORI);
        inst.i_lui  = (op == OP_LUI);
        inst.i_lw   = (op == OP_LW);
        inst.i_sw   = (op == OP_SW);
        inst.i_beq  = (op == OP_BEQ);
        inst.i_bne  = (op == OP_BNE);
        inst.i_j    = (op == OP_J);
        inst.i_jal  = (op == OP_JAL);
        inst.i_illegal = (inst == '0);
    end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multicycle control FSM (IF/ID/EXE/MEM/WB) driving the shared datapath ALU,
// register file and memory; only the state register is a flop.
module mc_ctrl_unit
    import mc_ctrl_unit_pkg::*;
#(
    parameter logic WAIT_MEM = 1'b1
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    input  logic       mrdy,
    output logic [3:0] aluc,
    output logic       wpc,
    output logic       wir,
    output logic       wmem,
    output logic       wreg,
    output logic       iord,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic       sext,
    output logic [1:0] pcsource,
    output logic       regrt,
    output logic       m2reg,
    output logic       jal,
    output logic       illegal,
    output logic [2:0] state
);

    inst_t      d;
    logic [2:0] state_q, nxt;
    logic       ready, r_alu, r_shift, i_alu;
    logic       wpc_r, wir_r, wmem_r, wreg_r, ill_r;

    mc_inst_dec u_dec (.op(op), .func(func), .inst(d));

    assign ready   = mrdy | ~WAIT_MEM;
    assign r_shift = d.i_sll | d.i_srl | d.i_sra;
    assign r_alu   = d.i_add | d.i_sub | d.i_and | d.i_or | d.i_xor | r_shift;
    assign i_alu   = d.i_addi | d.i_andi | d.i_ori | d.i_xori | d.i_lui;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state_q <= SIF;
        else       state_q <= nxt;
    end

    always_comb begin
        nxt = SIF;
        aluc = ALUC_ADD; iord = 1'b0; alusrca = 2'b00; alusrcb = 2'b00;
        sext = 1'b0; pcsource = 2'b00; regrt = 1'b0; m2reg = 1'b0; jal = 1'b0;
        wpc_r = 1'b0; wir_r = 1'b0; wmem_r = 1'b0; wreg_r = 1'b0; ill_r = 1'b0;
        case (state_q)
            SIF: begin
                alusrcb = 2'b01;
                wir_r   = ready;
                wpc_r   = ready;
                nxt     = ready ? SID : SIF;
            end
            SID: begin
                // ALU-out captures PC+4 + (imm<<2) for a possible branch
                alusrcb = 2'b11;
                sext    = 1'b1;
                if (d.i_j) begin
                    wpc_r = 1'b1; pcsource = 2'b10;
                end else if (d.i_jr) begin
                    wpc_r = 1'b1; pcsource = 2'b11;
                end else if (d.i_jal) begin
                    wpc_r = 1'b1; pcsource = 2'b10; wreg_r = 1'b1; jal = 1'b1;
                end else if (d.i_illegal) begin
                    ill_r = 1'b1;
                end else begin
                    nxt = SEXE;
                end
            end
            SEXE: begin
                if (r_alu) begin
                    alusrca = r_shift ? 2'b10 : 2'b01;
                    aluc    = alu_of(d);
                    nxt     = SWB;
                end else if (i_alu) begin
                    alusrca = 2'b01;
                    alusrcb = 2'b10;
                    sext    = d.i_addi;
                    aluc    = alu_of(d);
                    nxt     = SWB;
                end else if (d.i_lw || d.i_sw) begin
                    alusrca = 2'b01; alusrcb = 2'b10; sext = 1'b1;
                    nxt     = SMEM;
                end else if (d.i_beq || d.i_bne) begin
                    alusrca  = 2'b01;
                    aluc     = ALUC_SUB;
                    pcsource = 2'b01;
                    wpc_r    = (d.i_beq & z) | (d.i_bne & ~z);
                end
            end
            SMEM: begin
                iord = 1'b1;
                if (!ready)       nxt = SMEM;
                else if (d.i_sw)  wmem_r = 1'b1;
                else if (d.i_lw)  nxt = SWB;
            end
            SWB: begin
                wreg_r = 1'b1;
                regrt  = ~r_alu;
                m2reg  = d.i_lw;
            end
            default: nxt = SIF;
        endcase
    end

    // the state flop clears asynchronously, so SIF's enables must be masked too
    assign wpc     = wpc_r  & clrn;
    assign wir     = wir_r  & clrn;
    assign wmem    = wmem_r & clrn;
    assign wreg    = wreg_r & clrn;
    assign illegal = ill_r  & clrn;
    assign state   = state_q;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Randomized bench for mc_ctrl_unit: instructions drawn from a table, outputs
// compared each cycle against a phase-level model of the control rules.
module tb_mc_ctrl_unit;

    logic       clk = 1'b0, clrn = 1'b0;
    logic [5:0] op = '0, func = '0;
    logic       z = 1'b0, mrdy = 1'b1;
    logic [3:0] aluc;
    logic       wpc, wir, wmem, wreg, iord, sext, regrt, m2reg, jal, illegal;
    logic [1:0] alusrca, alusrcb, pcsource;
    logic [2:0] state;

    int errs = 0, checks = 0;

    mc_ctrl_unit #(.WAIT_MEM(1'b1)) dut (
        .clk(clk), .clrn(clrn), .op(op), .func(func), .z(z), .mrdy(mrdy),
        .aluc(aluc), .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg), .iord(iord),
        .alusrca(alusrca), .alusrcb(alusrcb), .sext(sext), .pcsource(pcsource),
        .regrt(regrt), .m2reg(m2reg), .jal(jal), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    localparam int K_R = 0, K_SH = 1, K_JR = 2, K_IMM = 3, K_LW = 4, K_SW = 5;
    localparam int K_BEQ = 6, K_BNE = 7, K_J = 8, K_JAL = 9, K_ILL = 10;
    localparam int NI = 24;

    // add sub and or xor sll srl sra jr addi andi ori xori lui lw sw beq bne j jal + 4 illegal
    logic [5:0] t_op [NI] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                              6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05,
                              6'h02, 6'h03, 6'h3f, 6'h00, 6'h01, 6'h00};
    logic [5:0] t_fn [NI] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03, 6'h08,
                              6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                              6'h00, 6'h00, 6'h00, 6'h01, 6'h00, 6'h2a};
    int         t_k  [NI] = '{K_R, K_R, K_R, K_R, K_R, K_SH, K_SH, K_SH, K_JR,
                              K_IMM, K_IMM, K_IMM, K_IMM, K_IMM, K_LW, K_SW, K_BEQ, K_BNE,
                              K_J, K_JAL, K_ILL, K_ILL, K_ILL, K_ILL};
    logic [3:0] t_alu[NI] = '{4'b0000, 4'b0100, 4'b0001, 4'b0101, 4'b0010, 4'b0011, 4'b0111,
                              4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0101, 4'b0010, 4'b0110,
                              4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000,
                              4'b0000, 4'b0000, 4'b0000, 4'b0000};

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] aluc;
        logic       wpc, wir, wmem, wreg, iord;
        logic [1:0] asa, asb;
        logic       sext;
        logic [1:0] pcs;
        logic       regrt, m2reg, jal, ill;
    } outs_t;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    // Phases are named by state code: 0 fetch, 1 decode, 2 execute, 3 memory, 4 write-back
    function automatic outs_t model(int k, int ph, logic [3:0] alu, logic zz, logic mr);
        outs_t e = '0;
        e.st = 3'(ph);
        case (ph)
            0: begin e.asb = 2'b01; e.wir = mr; e.wpc = mr; end
            1: begin
                e.asb = 2'b11; e.sext = 1'b1;
                if (k == K_J)   begin e.wpc = 1'b1; e.pcs = 2'b10; end
                if (k == K_JR)  begin e.wpc = 1'b1; e.pcs = 2'b11; end
                if (k == K_JAL) begin e.wpc = 1'b1; e.pcs = 2'b10; e.wreg = 1'b1; e.jal = 1'b1; end
                if (k == K_ILL) e.ill = 1'b1;
            end
            2: begin
                if (k == K_R || k == K_SH) begin
                    e.asa = (k == K_SH) ? 2'b10 : 2'b01; e.aluc = alu;
                end
                if (k == K_IMM) begin
                    e.asa = 2'b01; e.asb = 2'b10; e.aluc = alu; e.sext = (alu == 4'b0000);
                end
                if (k == K_LW || k == K_SW) begin e.asa = 2'b01; e.asb = 2'b10; e.sext = 1'b1; end
                if (k == K_BEQ || k == K_BNE) begin
                    e.asa = 2'b01; e.aluc = 4'b0100; e.pcs = 2'b01;
                    e.wpc = (k == K_BEQ) ? zz : ~zz;
                end
            end
            3: begin e.iord = 1'b1; e.wmem = (k == K_SW) && mr; end
            default: begin
                e.wreg = 1'b1; e.regrt = !(k == K_R || k == K_SH); e.m2reg = (k == K_LW);
            end
        endcase
        return e;
    endfunction

    task automatic compare(input outs_t e, input int k);
        chk("state", state, e.st);      chk("aluc", aluc, e.aluc);
        chk("wpc", wpc, e.wpc);         chk("wir", wir, e.wir);
        chk("wmem", wmem, e.wmem);      chk("wreg", wreg, e.wreg);
        chk("iord", iord, e.iord);      chk("alusrcb", alusrcb, e.asb);
        chk("sext", sext, e.sext);      chk("pcsource", pcsource, e.pcs);
        chk("regrt", regrt, e.regrt);   chk("m2reg", m2reg, e.m2reg);
        chk("jal", jal, e.jal);         chk("illegal", illegal, e.ill);
        // the A-source for ALU-immediate execute is left unchecked (rs by design intent)
        if (!(k == K_IMM && e.st == 3'd2)) chk("alusrca", alusrca, e.asa);
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the instruction.
    task automatic run_inst(input int idx, input int st_if, input int st_mem,
                            input int zsel, input bit rst_mem);
        int k = t_k[idx];
        int ph[$];
        ph = {0, 1};
        if (k == K_BEQ || k == K_BNE || k == K_R || k == K_SH || k == K_IMM || k == K_LW || k == K_SW)
            ph.push_back(2);
        if (k == K_LW || k == K_SW) ph.push_back(3);
        if (k == K_LW || k == K_R || k == K_SH || k == K_IMM) ph.push_back(4);
        op   = t_op[idx];
        func = (t_op[idx] == 6'h00) ? t_fn[idx] : 6'($urandom);
        foreach (ph[i]) begin
            int ns = (ph[i] == 0) ? st_if : (ph[i] == 3) ? st_mem : 0;
            for (int s = 0; s <= ns; s++) begin
                logic mr, zz;
                mr = (ph[i] == 0 || ph[i] == 3) ? (s == ns) : 1'($urandom);
                zz = (zsel == 2) ? 1'($urandom) : 1'(zsel);
                mrdy = mr; z = zz;
                #3;
                compare(model(k, ph[i], t_alu[idx], zz, mr), k);
                if (rst_mem && ph[i] == 3) begin
                    #1 clrn = 1'b0;
                    #1;
                    chk("rst_wmem", wmem, 0);  chk("rst_state", state, 0);
                    chk("rst_wir", wir, 0);    chk("rst_wpc", wpc, 0);
                    chk("rst_wreg", wreg, 0);
                    @(posedge clk); #1 clrn = 1'b1;
                    return;
                end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #2;
        chk("reset_state", state, 0); chk("reset_wir", wir, 0);
        chk("reset_wpc", wpc, 0);     chk("reset_illegal", illegal, 0);
        @(posedge clk); #1 clrn = 1'b1;

        run_inst(9, 0, 0, 2, 1'b0);   // addi
        run_inst(14, 0, 0, 2, 1'b0);  // lw
        run_inst(14, 0, 3, 2, 1'b0);  // lw, 3 memory stalls
        run_inst(16, 0, 0, 1, 1'b0);  // beq taken
        run_inst(16, 0, 0, 0, 1'b0);  // beq not taken
        run_inst(17, 0, 0, 1, 1'b0);  // bne not taken
        run_inst(17, 0, 0, 0, 1'b0);  // bne taken
        run_inst(5, 0, 0, 2, 1'b0);   // sll
        run_inst(7, 0, 0, 2, 1'b0);   // sra
        run_inst(4, 0, 0, 2, 1'b0);   // xor
        run_inst(19, 0, 0, 2, 1'b0);  // jal
        run_inst(20, 0, 0, 2, 1'b0);  // op 111111
        run_inst(15, 0, 0, 2, 1'b1);  // sw, reset in memory phase
        run_inst(9, 1, 0, 2, 1'b0);   // fetch resumes after reset

        for (int n = 0; n < 250; n++) begin
            int sif, smem;
            sif  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            smem = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_inst(int'($urandom_range(0, NI - 1)), sif, smem, 2, 1'b0);
        end

        #3 chk("final_state", state, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
